// File: rtl/counter_sequencer_pkg.sv
// Shared types and counter arithmetic for counter_sequencer.
// Build macro: COUNTER_SEQUENCER_SATURATE_EN selects clamping instead of modulo wrap.
package counter_sequencer_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             overflow;
    } op_result_t;

    localparam logic [MAX_W-1:0] ONE_W = 1;

    // Operands arrive zero-extended to MAX_W; width picks the live counter range.
    function automatic op_result_t apply_op(input logic [MAX_W-1:0] value,
                                            input op_t              op,
                                            input logic [MAX_W-1:0] data,
                                            input int unsigned      width);
        logic [MAX_W-1:0] ones;
        op_result_t       r;
        ones = {MAX_W{1'b1}};
        if (width < MAX_W) begin
            ones = ~({MAX_W{1'b1}} << width);
        end
        r.value    = value;
        r.overflow = 1'b0;
        case (op)
            OP_INC: begin
                if (value == ones) begin
                    r.overflow = 1'b1;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
                    r.value = ones;
`else
                    r.value = '0;
`endif
                end else begin
                    r.value = value + ONE_W;
                end
            end
            OP_DEC: begin
                if (value == '0) begin
                    r.overflow = 1'b1;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
                    r.value = '0;
`else
                    r.value = ones;
`endif
                end else begin
                    r.value = value - ONE_W;
                end
            end
            OP_LOAD: r.value = data & ones;
            default: r.value = value;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/counter_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the priority pointer.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] request,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_idx;

    // Scan from farthest to nearest so the entry closest to the pointer wins.
    always_comb begin
        win_idx     = '0;
        grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (request[(int'(ptr_q) + k) % N]) begin
                win_idx     = PW'((int'(ptr_q) + k) % N);
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Shared counter driven by several req/ack requesters through a two-state FSM.
// Build macro: COUNTER_SEQUENCER_SATURATE_EN clamps inc/dec at the range limits.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int REQUESTERS = 2
) (
    input  logic                        clock,
    input  logic                        reset_,
    input  logic [REQUESTERS-1:0]       req,
    input  logic [2*REQUESTERS-1:0]     op,
    input  logic [WIDTH*REQUESTERS-1:0] data,
    output logic [REQUESTERS-1:0]       ack,
    output logic [WIDTH-1:0]            value,
    output logic                        overflow
);

    state_t                  state_q, state_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    op_t                     op_q, op_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [WIDTH-1:0]        value_q, value_d;
    logic [REQUESTERS-1:0]   ack_q, ack_d;
    logic                    overflow_q, overflow_d;

    logic [REQUESTERS-1:0]   arb_req;
    logic [REQUESTERS-1:0]   arb_grant;
    logic                    arb_valid;
    logic                    arb_advance;
    op_t                     win_op;
    logic [WIDTH-1:0]        win_data;
    op_result_t              res;

    // The requester being acked still holds req this cycle; mask it so it cannot rerun.
    assign arb_req     = (state_q == IDLE) ? (req & ~ack_q) : '0;
    assign arb_advance = (state_q == IDLE);

    rr_arbiter #(
        .N (REQUESTERS)
    ) u_arb (
        .clock       (clock),
        .reset_      (reset_),
        .request     (arb_req),
        .advance     (arb_advance),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_comb begin
        win_op   = OP_HOLD;
        win_data = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (arb_grant[i]) begin
                win_op   = op_t'(op[2*i +: 2]);
                win_data = data[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        op_d       = op_q;
        data_d     = data_q;
        value_d    = value_q;
        ack_d      = '0;
        overflow_d = 1'b0;
        res        = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    op_d    = win_op;
                    data_d  = win_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res        = apply_op(MAX_W'(value_q), op_q, MAX_W'(data_q), WIDTH);
                value_d    = WIDTH'(res.value);
                overflow_d = res.overflow;
                ack_d      = grant_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            value_q    <= '0;
            ack_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            value_q    <= value_d;
            ack_q      <= ack_d;
            overflow_q <= overflow_d;
        end
    end

    // Operand latch is only consumed after a grant has loaded it, so it needs no reset.
    always_ff @(posedge clock) begin
        op_q   <= op_d;
        data_q <= data_d;
    end

    assign ack      = ack_q;
    assign value    = value_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized and directed bench for counter_sequencer with a transaction-level reference model.
module tb_counter_sequencer;

    localparam int W    = 16;
    localparam int R    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [R-1:0]     req;
    logic [2*R-1:0]   op;
    logic [W*R-1:0]   data;
    logic [R-1:0]     ack;
    logic [W-1:0]     value;
    logic             overflow;

    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH      (W),
        .REQUESTERS (R)
    ) dut (
        .clock    (clk),
        .reset_   (rst),
        .req      (req),
        .op       (op),
        .data     (data),
        .ack      (ack),
        .value    (value),
        .overflow (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side stimulus state
    bit r_req [R];
    int r_op  [R];
    int r_data[R];

    // Reference model: one pending operation, a rotating priority, last-acked requester
    int           m_value;
    int           m_ptr;
    bit           m_busy;
    int           m_win;
    int           m_op;
    int           m_data;
    int           m_acked;
    logic [R-1:0] exp_ack;
    logic         exp_ovf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_value = 0;
        m_ptr   = 0;
        m_busy  = 0;
        m_win   = 0;
        m_acked = -1;
        exp_ack = '0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_edge();
        int prev;
        exp_ack = '0;
        exp_ovf = 1'b0;
        if (m_busy) begin
            case (m_op)
                1: begin
                    if (m_value == MAXV) begin
                        exp_ovf = 1'b1;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
                        m_value = MAXV;
`else
                        m_value = 0;
`endif
                    end else m_value = m_value + 1;
                end
                2: begin
                    if (m_value == 0) begin
                        exp_ovf = 1'b1;
`ifdef COUNTER_SEQUENCER_SATURATE_EN
                        m_value = 0;
`else
                        m_value = MAXV;
`endif
                    end else m_value = m_value - 1;
                end
                3: m_value = m_data & MAXV;
                default: ;
            endcase
            exp_ack[m_win] = 1'b1;
            m_acked = m_win;
            m_busy  = 0;
        end else begin
            prev    = m_acked;
            m_acked = -1;
            for (int k = 0; k < R; k++) begin
                if (!m_busy && r_req[(m_ptr + k) % R] && ((m_ptr + k) % R) != prev) begin
                    m_win  = (m_ptr + k) % R;
                    m_busy = 1;
                end
            end
            if (m_busy) begin
                m_op   = r_op[m_win];
                m_data = r_data[m_win];
                m_ptr  = (m_win + 1) % R;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < R; i++) begin
            req[i]        = r_req[i];
            op[2*i +: 2]  = 2'(r_op[i]);
            data[W*i +: W] = W'(r_data[i]);
        end
    endtask

    task automatic step(input string tag);
        drive();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, ".ack"}, ack, exp_ack);
        chk({tag, ".value"}, value, m_value);
        chk({tag, ".ovf"}, overflow, exp_ovf);
    endtask

    // Present one op and step until its ack arrives; leaves the bench in the ack cycle.
    task automatic run_op(input int i, input int o, input int d);
        bit done;
        done     = 0;
        r_req[i]  = 1;
        r_op[i]   = o;
        r_data[i] = d;
        for (int s = 0; s < 8 && !done; s++) begin
            step("op");
            if (exp_ack[i]) done = 1;
        end
        chk("op_done", done, 1);
        r_req[i] = 0;
    endtask

    int           seen_val[$];
    int           seen_ack[$];
    int           ack_steps[$];
    bit           done;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < R; i++) begin
            r_req[i] = 0; r_op[i] = 0; r_data[i] = 0;
        end
        drive();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.ack", ack, 0);
        chk("rst.value", value, 0);
        chk("rst.ovf", overflow, 0);
        rst = 1'b0;

        // Load 0x1234 through requester 0: ack two edges after the sampled request
        r_req[0] = 1; r_op[0] = 3; r_data[0] = 'h1234;
        step("load.grant");
        chk("load.no_early_ack", ack, 0);
        step("load.exec");
        chk("load.ack0", ack, 2'b01);
        chk("load.val", value, 'h1234);
        chk("load.ovf", overflow, 0);
        r_req[0] = 0;

        // Boundary: inc at all-ones
        run_op(0, 3, 'hFFFF);
        run_op(0, 1, 0);
`ifdef COUNTER_SEQUENCER_SATURATE_EN
        chk("wrap.val", value, 'hFFFF);
`else
        chk("wrap.val", value, 'h0000);
`endif
        chk("wrap.ovf", overflow, 1);

        // Boundary: dec at zero
        run_op(0, 3, 0);
        run_op(0, 2, 0);
`ifdef COUNTER_SEQUENCER_SATURATE_EN
        chk("under.val", value, 'h0000);
`else
        chk("under.val", value, 'hFFFF);
`endif
        chk("under.ovf", overflow, 1);

        // Two held requesters alternate; loading via requester 1 leaves priority at 0
        run_op(1, 3, 5);
        r_req[0] = 1; r_op[0] = 1;
        r_req[1] = 1; r_op[1] = 2;
        for (int s = 0; s < 8; s++) begin
            step("alt");
            if (ack != 0) begin
                seen_val.push_back(int'(value));
                seen_ack.push_back(int'(ack));
            end
        end
        chk("alt.count", seen_val.size(), 4);
        for (int j = 0; j < 4 && j < seen_val.size(); j++) begin
            chk("alt.val", seen_val[j], (j % 2 == 0) ? 6 : 5);
            chk("alt.ack", seen_ack[j], (j % 2 == 0) ? 1 : 2);
        end
        r_req[0] = 0; r_req[1] = 0;
        step("alt.idle");

        // Held request is masked in its ack cycle: acks three cycles apart
        r_req[0] = 1; r_op[0] = 1;
        for (int s = 1; s <= 5; s++) begin
            step("held");
            if (ack[0]) ack_steps.push_back(s);
        end
        chk("held.count", ack_steps.size(), 2);
        if (ack_steps.size() == 2) begin
            chk("held.first", ack_steps[0], 2);
            chk("held.second", ack_steps[1], 5);
        end
        chk("held.val", value, 7);
        r_req[0] = 0;

        // Hold op
        run_op(0, 0, 0);
        chk("hold.val", value, 7);
        chk("hold.ovf", overflow, 0);
        chk("hold.ack", ack, 2'b01);

        // Reset during EXEC of a load 0xABCD from requester 1
        run_op(0, 1, 0);
        r_req[1] = 1; r_op[1] = 3; r_data[1] = 'hABCD;
        step("rx.grant");
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rx.ack", ack, 0);
        chk("rx.val", value, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rx.ack_hold", ack, 0);
        chk("rx.val_hold", value, 0);
        chk("rx.ovf_hold", overflow, 0);
        rst = 1'b0;
        r_req[0] = 1; r_op[0] = 1;
        step("rx.regrant");
        step("rx.exec0");
        chk("rx.first_ack0", ack, 2'b01);
        chk("rx.val1", value, 1);
        r_req[0] = 0;
        done = 0;
        for (int s = 0; s < 8 && !done; s++) begin
            step("rx.req1");
            if (exp_ack[1]) done = 1;
        end
        chk("rx.req1_done", done, 1);
        chk("rx.val_abcd", value, 'hABCD);
        r_req[1] = 0;

        // Randomized traffic; boundary operands favoured
        for (int c = 0; c < 400; c++) begin
            step("rand");
            for (int i = 0; i < R; i++) begin
                if (!r_req[i] || exp_ack[i]) begin
                    r_req[i] = ($urandom_range(0, 3) != 0);
                    r_op[i]  = int'($urandom_range(0, 3));
                    case ($urandom_range(0, 3))
                        0: r_data[i] = MAXV;
                        1: r_data[i] = 0;
                        default: r_data[i] = int'($urandom_range(0, MAXV));
                    endcase
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Shares one WIDTH-bit counter register between REQUESTERS independent requesters, such as mouse input and a timer tick. Each requester issues load/inc/dec/hold operations over a req/ack handshake. A round-robin arbiter picks one requester and a two-state FSM executes its operation on the counter. The block owns the counter and drives `value` to downstream display/datapath logic.

## Interface
- `WIDTH`, 16: counter and operand width.
- `REQUESTERS`, 2: number of requesters, 2..8.
- `clock`  in  1: sole clock, all state on posedge.
- `reset_`  in  1: asynchronous, active-high reset.
- `req`  in  REQUESTERS: request per requester; held until its `ack`.
- `op`  in  2*REQUESTERS: op per requester, slice i = `op[2i+1:2i]`. Encoding: 00 hold, 01 inc, 10 dec, 11 load.
- `data`  in  WIDTH*REQUESTERS: load operand per requester, slice i = `data[WIDTH*i +: WIDTH]`.
- `ack`  out  REQUESTERS: one-hot, one-cycle completion pulse.
- `value`  out  WIDTH: current counter value (registered).
- `overflow`  out  1: one-cycle pulse when inc/dec crosses the range boundary.

## Operation
- FSM states: IDLE, EXEC.
- **IDLE**
  - Eligible requests = `req` with the bit of the currently asserted `ack` masked off.
  - If any request is eligible: the arbiter grants one, and `op`/`data` of the winner are latched. Next state is EXEC.
  - Otherwise stay in IDLE.
- **EXEC**
  - Apply the latched op to the counter.
  - Assert `ack[grant]` (registered) and return to IDLE.
  - `req`, `op` and `data` are not sampled in EXEC.
- **Ops**
  - hold: value unchanged, still acked.
  - inc: value+1.
  - dec: value−1.
  - load: value = latched data.
- **Arithmetic** (modulo 2^WIDTH by default)
  - inc of all-ones → 0, with `overflow`.
  - dec of 0 → all-ones, with `overflow`.
  - load never sets `overflow`.
- **Round-robin**
  - Priority pointer p starts at 0 on reset.
  - Grant = first eligible index searching p, p+1, … mod REQUESTERS.
  - After a grant to i, p = (i+1) mod REQUESTERS.
- **Handshake**
  - Requester keeps `req`, `op` and `data` stable from assertion until the cycle `ack` is high.
  - It may drop `req` or present a new op in the cycle after `ack`.
  - Changing `op`/`data` before `ack` is undefined.
- **Reset values**: `value`=0, `ack`=0, `overflow`=0, state IDLE, p=0.
- **Reset mid-EXEC**: the latched op is discarded, no `ack` is issued, and the counter stays 0. Requesters must re-present.

## Timing
- Request seen at IDLE edge N.
- Counter update at edge N+1.
- `ack` and `overflow` high during cycle N+1→N+2, coincident with the new `value`.
- Latency: 2 edges from sampled `req` to visible `value`.
- Peak throughput: 1 op per 2 cycles. Back-to-back grants to different requesters need no gap.
- A granted requester that holds `req` through its `ack` cycle is masked for that cycle, so it is never executed twice.
- Simultaneous requests: exactly one granted per IDLE cycle. Losers wait with `req` held. Worst-case wait is 2*(REQUESTERS−1) cycles.
- `ack` is never asserted while in IDLE except for the single cycle following EXEC.

## Configuration
- `COUNTER_SEQUENCER_SATURATE_EN`
- **Defined**
  - inc at all-ones holds all-ones.
  - dec at 0 holds 0.
  - `overflow` still pulses on the clamped attempt.
- **Undefined**: modulo wrap as above.
- Handshake, latency and arbitration are identical in both builds.

## Structure
- **Package `counter_sequencer_pkg`**
  - `op_t` enum: OP_HOLD=2'b00, OP_INC=2'b01, OP_DEC=2'b10, OP_LOAD=2'b11.
  - `state_t` enum: IDLE, EXEC.
  - Function `apply_op(value, op, data)` returning next value and overflow, honoring the saturate macro.
- **Sub-module `rr_arbiter`** (parameter N)
  - Inputs: `clock`, `reset_`, `request[N]`, `advance`.
  - Outputs: one-hot `grant[N]`, `grant_valid`.
  - Owns the priority pointer; `advance` updates it on a taken grant.
- **Top level**: FSM, op/data latch, counter register, ack/overflow registers.

## Test plan
- Reset, then req[0]=1, op=load, data=0x1234 → `ack[0]` pulse 2 edges later; `value`=0x1234; `overflow`=0.
- Load 0xFFFF, then inc → wrap build: `value`=0x0000 with `overflow` pulse. Saturate build: `value`=0xFFFF with `overflow` pulse.
- req[0] (inc) and req[1] (dec) held continuously from value 5 → grants alternate 0,1,0,1; `value` toggles 6,5,6,5; one `ack` every 2 cycles.
- req[0] held high after its ack with the same inc op → next grant occurs 2 cycles after ack, not in the ack cycle; `value` increments exactly once per ack.
- `reset_` asserted during EXEC of a load 0xABCD → no `ack`; `value`=0; p=0; after release the held req[1] is granted before req[0]? No: with p=0, req[0] wins first.
- hold op from value 7 → `ack` pulse, `value` stays 7, `overflow`=0.
